// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_scheduler
//  Description : Sits between fetch and decode. Buffers up to two non-NOP
//                instructions in program order and issues 0, 1 or 2 of them
//                per cycle. A per-register countdown scoreboard holds back
//                any instruction whose sources are still being produced.
//
//  Ports
//    clk, rst                  clock (rising edge), synchronous active-high reset
//    fetch_valid               fetch offers an instruction pair this cycle
//    fetch_instr1/2            older / younger instruction of the pair
//    fetch_ready               pair is accepted this cycle (independent of fetch_valid)
//    flush                     drop buffered, not-yet-issued instructions
//    issue_valid1/2            registered issue strobes (older / younger slot)
//    issue_instr1/2            registered issued instructions, zero when not valid
//    stall                     oldest buffered entry is blocked this cycle
//    busy_mask                 bit r set while register r has a pending write
//
//  Instruction fields: op[15:12] imm[11] rd[10:8] rs1[7:5] rs2[4:2]
//
//  Revision    : 1.0  initial release
// ============================================================================
module dual_issue_scheduler #(
    parameter int IW      = 16,
    parameter int NREG    = 8,
    parameter int HAZ_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_valid,
    input  logic [IW-1:0]   fetch_instr1,
    input  logic [IW-1:0]   fetch_instr2,
    output logic            fetch_ready,
    input  logic            flush,
    output logic            issue_valid1,
    output logic [IW-1:0]   issue_instr1,
    output logic            issue_valid2,
    output logic [IW-1:0]   issue_instr2,
    output logic            stall,
    output logic [NREG-1:0] busy_mask
);

    localparam int                 c_CNT_W = $clog2(HAZ_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_HAZ   = c_CNT_W'(HAZ_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------
    // Holding buffer: slot0 is always the oldest entry
    // ------------------------------------------------------------------
    logic [IW-1:0] r_slot0;
    logic [IW-1:0] r_slot1;
    logic [1:0]    r_count;

    // Field extraction for both buffered entries
    logic [2:0] w_rd0, w_rs10, w_rs20;
    logic [2:0] w_rd1, w_rs11, w_rs21;
    logic       w_imm0, w_imm1;

    assign w_imm0 = r_slot0[11];
    assign w_rd0  = r_slot0[10:8];
    assign w_rs10 = r_slot0[7:5];
    assign w_rs20 = r_slot0[4:2];
    assign w_imm1 = r_slot1[11];
    assign w_rd1  = r_slot1[10:8];
    assign w_rs11 = r_slot1[7:5];
    assign w_rs21 = r_slot1[4:2];

    // ------------------------------------------------------------------
    // Issue decision (combinational on registered state)
    // ------------------------------------------------------------------
    logic w_blk0;      // slot0 reads a busy register
    logic w_blk1;      // slot1 reads a busy register
    logic w_raw;       // slot1 reads slot0's destination
    logic w_waw;       // slot1 and slot0 write the same register
    logic w_issue0;
    logic w_issue1;
    logic w_all_issue;
    logic w_xfer;
    logic w_do0;       // issue that actually commits (flush overrides)
    logic w_do1;

    // rs2 only counts as a source for register-register forms (imm == 0)
    assign w_blk0 = busy_mask[w_rs10] || (!w_imm0 && busy_mask[w_rs20]);
    assign w_blk1 = busy_mask[w_rs11] || (!w_imm1 && busy_mask[w_rs21]);
    assign w_raw  = (w_rs11 == w_rd0) || (!w_imm1 && (w_rs21 == w_rd0));
    assign w_waw  = (w_rd1 == w_rd0);

    assign w_issue0 = (r_count != 2'd0) && !w_blk0;
    assign w_issue1 = (r_count == 2'd2) && w_issue0 && !w_blk1 && !w_raw && !w_waw;

    // The buffer drains completely this cycle, so a new pair can take its place
    assign w_all_issue = ((r_count == 2'd1) && w_issue0) ||
                         ((r_count == 2'd2) && w_issue1);

    assign fetch_ready = !flush && ((r_count == 2'd0) || w_all_issue);
    assign w_xfer      = fetch_valid && fetch_ready;
    assign stall       = (r_count != 2'd0) && w_blk0;

    assign w_do0 = w_issue0 && !flush;
    assign w_do1 = w_issue1 && !flush;

    // ------------------------------------------------------------------
    // Incoming pair: NOPs are squeezed out so slot0 stays the oldest
    // ------------------------------------------------------------------
    logic w_live1, w_live2;

    assign w_live1 = (fetch_instr1[15:12] != 4'h0);
    assign w_live2 = (fetch_instr2[15:12] != 4'h0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else if (w_xfer) begin
            // Transfer only happens once the old contents have fully issued
            r_slot0 <= w_live1 ? fetch_instr1 : fetch_instr2;
            r_slot1 <= fetch_instr2;
            r_count <= {1'b0, w_live1} + {1'b0, w_live2};
        end else if (w_issue1) begin
            r_count <= 2'd0;
        end else if (w_issue0) begin
            if (r_count == 2'd2) begin
                r_slot0 <= r_slot1;
                r_count <= 2'd1;
            end else begin
                r_count <= 2'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered issue outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issue_valid1 <= 1'b0;
            issue_instr1 <= '0;
            issue_valid2 <= 1'b0;
            issue_instr2 <= '0;
        end else begin
            issue_valid1 <= w_issue0;
            issue_instr1 <= w_issue0 ? r_slot0 : '0;
            issue_valid2 <= w_issue1;
            issue_instr2 <= w_issue1 ? r_slot1 : '0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one saturating down-counter per register. An issue
    // reloads the destination counter; flush does not stop the decay
    // because already-issued writes are still in flight.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NREG; g++) begin : g_cnt
        localparam logic [2:0] c_IDX = 3'(g);
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if ((w_do0 && (w_rd0 == c_IDX)) || (w_do1 && (w_rd1 == c_IDX))) begin
                r_cnt <= c_HAZ;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end

        assign busy_mask[g] = (r_cnt != '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_issue_scheduler
//  Description : Self-checking bench for dual_issue_scheduler. A table of
//                hand-derived cycle vectors covers the directed scenarios,
//                then randomized traffic is compared cycle by cycle against
//                a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dual_issue_scheduler;

    localparam int HAZ = 2;

    localparam logic [15:0] c_A = 16'h114C;  // r1 <= r2, r3
    localparam logic [15:0] c_B = 16'h14B8;  // r4 <= r5, r6
    localparam logic [15:0] c_C = 16'h1438;  // r4 <= r1, r6
    localparam logic [15:0] c_D = 16'h2D44;  // r5 <= r2 (imm)
    localparam logic [15:0] c_E = 16'h11B8;  // r1 <= r5, r6
    localparam logic [15:0] c_N = 16'h0000;  // NOP

    logic        clk = 1'b0;
    logic        rst, flush, fetch_valid;
    logic [15:0] fetch_instr1, fetch_instr2;
    logic        fetch_ready, issue_valid1, issue_valid2, stall;
    logic [15:0] issue_instr1, issue_instr2;
    logic [7:0]  busy_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.IW(16), .NREG(8), .HAZ_LAT(HAZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_valid  (fetch_valid),
        .fetch_instr1 (fetch_instr1),
        .fetch_instr2 (fetch_instr2),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .issue_valid1 (issue_valid1),
        .issue_instr1 (issue_instr1),
        .issue_valid2 (issue_valid2),
        .issue_instr2 (issue_instr2),
        .stall        (stall),
        .busy_mask    (busy_mask)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst          = r;
        flush        = f;
        fetch_valid  = v;
        fetch_instr1 = a;
        fetch_instr2 = b;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic efr, input logic ev1,
                           input logic [15:0] eo1, input logic ev2, input logic [15:0] eo2,
                           input logic est, input logic [7:0] ebm);
        chk({tag, ".fetch_ready"},  32'(fetch_ready),  32'(efr));
        chk({tag, ".issue_valid1"}, 32'(issue_valid1), 32'(ev1));
        chk({tag, ".issue_instr1"}, 32'(issue_instr1), 32'(eo1));
        chk({tag, ".issue_valid2"}, 32'(issue_valid2), 32'(ev2));
        chk({tag, ".issue_instr2"}, 32'(issue_instr2), 32'(eo2));
        chk({tag, ".stall"},        32'(stall),        32'(est));
        chk({tag, ".busy_mask"},    32'(busy_mask),    32'(ebm));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: one row per cycle
    // ------------------------------------------------------------------
    typedef struct {
        logic        r, f, v;
        logic [15:0] i1, i2;
        logic        fr, v1;
        logic [15:0] o1;
        logic        v2;
        logic [15:0] o2;
        logic        st;
        logic [7:0]  bm;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic v,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic efr, input logic ev1, input logic [15:0] eo1,
                       input logic ev2, input logic [15:0] eo2,
                       input logic est, input logic [7:0] ebm);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.i1 = a; t.i2 = b;
        t.fr = efr; t.v1 = ev1; t.o1 = eo1; t.v2 = ev2; t.o2 = eo2;
        t.st = est; t.bm = ebm;
        tbl.push_back(t);
    endtask

    task automatic idle(input logic efr, input logic ev1, input logic [15:0] eo1,
                        input logic ev2, input logic [15:0] eo2,
                        input logic est, input logic [7:0] ebm);
        add(0, 0, 0, c_N, c_N, efr, ev1, eo1, ev2, eo2, est, ebm);
    endtask

    // ------------------------------------------------------------------
    // Reference model: program-order queue plus integer countdowns
    // ------------------------------------------------------------------
    logic [15:0] mq[$];
    int          mcnt[8];
    logic        mv1, mv2;
    logic [15:0] mi1, mi2;

    function automatic int f_rd(input logic [15:0] ins);
        return int'(ins[10:8]);
    endfunction

    function automatic bit m_reads(input logic [15:0] ins, input int r);
        return (int'(ins[7:5]) == r) || (!ins[11] && (int'(ins[4:2]) == r));
    endfunction

    function automatic bit m_blocked(input logic [15:0] ins);
        for (int r = 0; r < 8; r++)
            if (mcnt[r] > 0 && m_reads(ins, r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [3:0] op;
        if ($urandom_range(3) == 0) return 16'h0000;
        op = 4'($urandom_range(15, 1));
        return {op, 1'($urandom_range(1)), 3'($urandom_range(3)),
                3'($urandom_range(3)), 3'($urandom_range(3)), 2'($urandom_range(3))};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 8; r++) mcnt[r] = 0;
        mv1 = 0; mv2 = 0; mi1 = 16'h0; mi2 = 16'h0;
    endtask

    initial begin
        int n;
        logic efr, est, r, f, v;
        logic [7:0] ebm;
        logic [15:0] a, b;

        rst = 1; flush = 0; fetch_valid = 0; fetch_instr1 = 0; fetch_instr2 = 0;
        drive(1, 0, 0, c_N, c_N);
        drive(1, 0, 0, c_N, c_N);

        // Idle after reset
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Independent pair issues together
        add(0, 0, 1, c_A, c_B, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_A, 1, c_B, 0, 8'h12);
        idle(1, 0, c_N, 0, c_N, 0, 8'h12);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // RAW pair: C waits HAZ_LAT+1 cycles behind A
        add(0, 0, 1, c_A, c_C, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 1, c_A, 0, c_N, 1, 8'h02);
        idle(0, 0, c_N, 0, c_N, 1, 8'h02);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_C, 0, c_N, 0, 8'h10);
        idle(1, 0, c_N, 0, c_N, 0, 8'h10);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Immediate form ignores rs2
        add(0, 0, 1, c_A, c_D, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_A, 1, c_D, 0, 8'h22);
        idle(1, 0, c_N, 0, c_N, 0, 8'h22);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // WAW split without scoreboard stall
        add(0, 0, 1, c_A, c_E, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_A, 0, c_N, 0, 8'h02);
        idle(1, 1, c_E, 0, c_N, 0, 8'h02);
        idle(1, 0, c_N, 0, c_N, 0, 8'h02);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // NOP handling
        add(0, 0, 1, c_N, c_N, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        add(0, 0, 1, c_N, c_B, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_B, 0, c_N, 0, 8'h10);
        idle(1, 0, c_N, 0, c_N, 0, 8'h10);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Flush of a blocked entry
        add(0, 0, 1, c_A, c_C, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 1, c_A, 0, c_N, 1, 8'h02);
        add(0, 1, 0, c_N, c_N, 0, 0, c_N, 0, c_N, 1, 8'h02);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Reset of a blocked entry
        add(0, 0, 1, c_A, c_C, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(0, 1, c_A, 0, c_N, 1, 8'h02);
        add(1, 0, 0, c_N, c_N, 0, 0, c_N, 0, c_N, 1, 8'h02);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Reset clears live counters
        add(0, 0, 1, c_A, c_B, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        add(1, 0, 0, c_N, c_N, 1, 1, c_A, 1, c_B, 0, 8'h12);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Flush overrides an issue decision
        add(0, 0, 1, c_A, c_B, 1, 0, c_N, 0, c_N, 0, 8'h00);
        add(0, 1, 0, c_N, c_N, 0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // No transfer during flush even with fetch_valid
        add(0, 1, 1, c_A, c_B, 0, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);
        // Back-to-back pairs with no bubble
        add(0, 0, 1, c_A, c_B, 1, 0, c_N, 0, c_N, 0, 8'h00);
        add(0, 0, 1, c_D, c_A, 1, 0, c_N, 0, c_N, 0, 8'h00);
        idle(1, 1, c_A, 1, c_B, 0, 8'h12);
        idle(1, 1, c_D, 1, c_A, 0, 8'h32);
        idle(1, 0, c_N, 0, c_N, 0, 8'h22);
        idle(1, 0, c_N, 0, c_N, 0, 8'h00);

        foreach (tbl[k]) begin
            drive(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].i1, tbl[k].i2);
            chk_all($sformatf("vec%0d", k), tbl[k].fr, tbl[k].v1, tbl[k].o1,
                    tbl[k].v2, tbl[k].o2, tbl[k].st, tbl[k].bm);
            @(posedge clk);
        end

        // Randomized phase against the reference model
        drive(1, 0, 0, c_N, c_N);
        model_reset();
        @(posedge clk);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = ($urandom_range(127) == 0);
            f = ($urandom_range(15) == 0);
            v = ($urandom_range(2) != 0);
            a = rnd_instr();
            b = rnd_instr();
            drive(r, f, v, a, b);

            n = 0;
            if (mq.size() > 0 && !m_blocked(mq[0])) begin
                n = 1;
                if (mq.size() == 2 && !m_blocked(mq[1]) &&
                    !m_reads(mq[1], f_rd(mq[0])) && f_rd(mq[1]) != f_rd(mq[0]))
                    n = 2;
            end
            efr = !f && (n == mq.size());
            est = (mq.size() > 0) && m_blocked(mq[0]);
            for (int q = 0; q < 8; q++) ebm[q] = (mcnt[q] > 0);
            chk_all("rand", efr, mv1, mi1, mv2, mi2, est, ebm);

            if (r) begin
                model_reset();
            end else begin
                for (int q = 0; q < 8; q++) if (mcnt[q] > 0) mcnt[q]--;
                if (f) begin
                    mq.delete();
                    mv1 = 0; mv2 = 0; mi1 = 16'h0; mi2 = 16'h0;
                end else begin
                    mv1 = (n >= 1); mi1 = (n >= 1) ? mq[0] : 16'h0;
                    mv2 = (n == 2); mi2 = (n == 2) ? mq[1] : 16'h0;
                    if (n >= 1) mcnt[f_rd(mq[0])] = HAZ;
                    if (n == 2) mcnt[f_rd(mq[1])] = HAZ;
                    repeat (n) void'(mq.pop_front());
                    if (v && efr) begin
                        if (a[15:12] != 4'h0) mq.push_back(a);
                        if (b[15:12] != 4'h0) mq.push_back(b);
                    end
                end
            end
            @(posedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
